regfile_scoreboard: RTL

//  Parametrised general-purpose register file for the RISC-V PE, replacing the fixed 32x32 two-read store.
//  - One write port; NRD synchronous read ports with a registered output (1-cycle latency).
//  - Write-to-read bypass, and x0 hardwired to zero when ZERO_REG=1.
//  - Per-register pending-write scoreboard: flags read-after-write hazards to the PE controller so it can stall.

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/rf_read_port.sv | 53 +++++
 rtl/regfile_scoreboard.sv | 95 +++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the parametrised register file with pending-write scoreboard.
package rf_pkg;

  localparam int unsigned RF_DATA_W    = 32;
  localparam int unsigned RF_NREGS     = 32;
  localparam int unsigned RF_NRD       = 2;
  localparam int unsigned RF_ZERO_ADDR = 0;

  // Address width for a register count; at least one bit so a 1-entry file still elaborates.
  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of writeback, issue and read signals between the PE controller and the register file.
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = rf_pkg::RF_DATA_W,
  parameter int unsigned NREGS  = rf_pkg::RF_NREGS,
  parameter int unsigned NRD    = rf_pkg::RF_NRD
);

  localparam int unsigned AW = rf_pkg::rf_aw(NREGS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic                  rd_en;
  logic [NRD*AW-1:0]     rs_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  rd_valid;
  logic [NRD-1:0]        rs_hazard;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_rd, rd_en, rs_addr,
    input  rd_data, rd_valid, rs_hazard, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_rd, rd_en, rs_addr,
    output rd_data, rd_valid, rs_hazard, busy_vec
  );

endinterface

// File: rtl/rf_read_port.sv
// One read port: x0 masking, write-to-read bypass, hazard term and the registered output.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rs_addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              busy_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              hazard_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic              is_zero;
  logic              fwd;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    is_zero = ZERO_REG && (rs_addr_i == AW'(RF_ZERO_ADDR));
    fwd     = BYPASS && wr_en_i && (wr_addr_i == rs_addr_i);
    // x0 masking comes first, which also hides a dropped write to x0 from the bypass path.
    if (is_zero) begin
      src = '0;
    end else if (fwd) begin
      src = wr_data_i;
    end else begin
      src = reg_data_i;
    end
    hazard_o  = busy_i & ~fwd;
    rd_data_d = rd_en_i ? src : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised GPR file with NRD registered read ports and a per-register pending-write scoreboard.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NRD      = RF_NRD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned AW = rf_aw(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic [NRD-1:0]    hazard;
  logic              wr_drop;

  assign wr_drop = ZERO_REG && (bus.wr_addr == AW'(RF_ZERO_ADDR));

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !wr_drop) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // A new issue wins over a writeback to the same register in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned a = 0; a < NREGS; a++) begin
      if (bus.iss_en && (bus.iss_rd == AW'(a))) begin
        busy_d[a] = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == AW'(a))) begin
        busy_d[a] = 1'b0;
      end
    end
    if (ZERO_REG) begin
      busy_d[RF_ZERO_ADDR] = 1'b0;
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_en & ~|hazard;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd_port
    logic [AW-1:0] addr;
    assign addr = bus.rs_addr[p*AW +: AW];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .clk_i      (clk),
      .rst_ni     (reset),
      .rd_en_i    (bus.rd_en),
      .rs_addr_i  (addr),
      .reg_data_i (regs_q[addr]),
      .busy_i     (busy_q[addr]),
      .wr_en_i    (bus.wr_en),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .hazard_o   (hazard[p]),
      .rd_data_o  (bus.rd_data[p*DATA_W +: DATA_W])
    );
  end

  assign bus.rs_hazard = hazard;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy_vec  = busy_q;

endmodule
